// File: rtl/rr_mux_arbiter_pkg.sv
// Shared defaults and helpers for the round-robin mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int DEF_NCH = 4;
    localparam int DEF_W   = 8;

    // Modular add of a small step, without a divider; base < n and step <= n.
    function automatic int rr_wrap(input int base, input int step, input int n);
        int sum;
        sum = base + step;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/mux_defs.vh
// Mode encodings shared by the arbiter and anything that drives its mode input.
`ifndef MUX_DEFS_VH
`define MUX_DEFS_VH
`define MODE_RR    1'b0
`define MODE_FIXED 1'b1
`endif

// File: rtl/rr_mux_arbiter_onehot_decoder.sv
// Index + enable to one-hot; an index with no matching channel yields all zeros.
module onehot_decoder #(
    parameter int NCH  = 4,
    parameter int SELW = 2
) (
    input  logic [SELW-1:0] idx_i,
    input  logic            en_i,
    output logic [NCH-1:0]  onehot_o
);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_bit
        assign onehot_o[gi] = en_i && (idx_i == SELW'(gi));
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// NCH:1 valid/ready multiplexer with round-robin or fixed-select arbitration
// and a single registered output stage.
`include "mux_defs.vh"

module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter  int NCH  = DEF_NCH,
    parameter  int W    = DEF_W,
    localparam int SELW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [SELW-1:0]  fix_sel,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SELW-1:0]  out_ch,
    input  logic             out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            load_en;
    logic            rr_found;
    logic [SELW-1:0] rr_idx;
    logic [SELW-1:0] rr_cand;
    logic            fix_ok;
    logic            grant_any;
    logic [SELW-1:0] grant_idx;
    logic            grant_en;
    logic [NCH-1:0]  grant_oh;
    logic            xfer;
    logic [W-1:0]    masked [NCH];
    logic [W-1:0]    sel_data;

    assign load_en = !out_valid_q || out_ready;

    // Search starts just after the last served channel so every requester
    // is reached within NCH grants.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NCH; k++) begin
            rr_cand = SELW'(rr_wrap(int'(ptr_q), k, NCH));
            if (!rr_found && in_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    assign fix_ok = (int'(fix_sel) < NCH) && in_valid[fix_sel];

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (mode == `MODE_RR) begin
            grant_any = rr_found;
            grant_idx = rr_idx;
        end else begin
            grant_any = fix_ok;
            grant_idx = fix_sel;
        end
    end

    assign grant_en = grant_any && !rst;

    onehot_decoder #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_grant_dec (
        .idx_i    (grant_idx),
        .en_i     (grant_en),
        .onehot_o (grant_oh)
    );

    assign in_ready = grant_oh & {NCH{load_en}};
    assign xfer     = |(in_valid & in_ready);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_mask
        assign masked[gi] = in_data[gi*W +: W] & {W{grant_oh[gi]}};
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            sel_data = sel_data | masked[i];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = sel_data;
                out_ch_d    = grant_idx;
                ptr_d       = grant_idx;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= SELW'(NCH - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed vector bench for rr_mux_arbiter (NCH=4, W=8).
module tb_rr_mux_arbiter;

    localparam int NCH  = 4;
    localparam int W    = 8;
    localparam int SELW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             mode;
    logic [SELW-1:0]  fix_sel;
    logic [NCH-1:0]   in_valid;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SELW-1:0]  out_ch;
    logic             out_ready;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.NCH(NCH), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .fix_sel   (fix_sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    typedef struct {
        logic            rst;
        logic            mode;
        logic [SELW-1:0] fix_sel;
        logic [NCH-1:0]  valid;
        logic            ordy;
        logic [NCH-1:0]  exp_rdy;
        logic            exp_ov;
        logic [W-1:0]    exp_od;
        logic [SELW-1:0] exp_ch;
    } vec_t;

    vec_t vecs [$];
    int   applied = 0;
    int   errors  = 0;

    function automatic void add(input logic r, input logic m, input logic [SELW-1:0] fs,
                                input logic [NCH-1:0] v, input logic ordy,
                                input logic [NCH-1:0] er, input logic eov,
                                input logic [W-1:0] eod, input logic [SELW-1:0] ech);
        vec_t t;
        t.rst = r; t.mode = m; t.fix_sel = fs; t.valid = v; t.ordy = ordy;
        t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_ch = ech;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [NCH-1:0] er, input logic eov,
                         input logic [W-1:0] eod, input logic [SELW-1:0] ech);
        applied++;
        if (in_ready !== er || out_valid !== eov || out_data !== eod || out_ch !== ech) begin
            errors++;
            $display("FAIL %s: got rdy=%b ov=%b od=%h ch=%0d, want rdy=%b ov=%b od=%h ch=%0d",
                     name, in_ready, out_valid, out_data, out_ch, er, eov, eod, ech);
        end else begin
            $display("ok   %s: rdy=%b ov=%b od=%h ch=%0d", name, in_ready, out_valid, out_data, out_ch);
        end
    endtask

    initial begin
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        rst       = 1'b1;
        mode      = 1'b0;
        fix_sel   = '0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        @(posedge clk); #1;

        //   rst mode sel valid  ordy  exp_rdy ov  od     ch
        add(1, 0, 0, 4'hF,  1, 4'b0000, 0, 8'h00, 0);   // reset, all requesting
        add(1, 0, 0, 4'hF,  1, 4'b0000, 0, 8'h00, 0);
        add(0, 0, 0, 4'hF,  1, 4'b0001, 0, 8'h00, 0);   // fairness 0,1,2,3,0
        add(0, 0, 0, 4'hF,  1, 4'b0010, 1, 8'h10, 0);
        add(0, 0, 0, 4'hF,  1, 4'b0100, 1, 8'h11, 1);
        add(0, 0, 0, 4'hF,  1, 4'b1000, 1, 8'h12, 2);
        add(0, 0, 0, 4'hF,  1, 4'b0001, 1, 8'h13, 3);
        add(0, 0, 0, 4'hA,  1, 4'b0010, 1, 8'h10, 0);   // sparse ch1/ch3
        add(0, 0, 0, 4'hA,  1, 4'b1000, 1, 8'h11, 1);
        add(0, 0, 0, 4'hA,  1, 4'b0010, 1, 8'h13, 3);
        add(0, 0, 0, 4'hA,  1, 4'b1000, 1, 8'h11, 1);
        add(0, 0, 0, 4'hF,  0, 4'b0000, 1, 8'h13, 3);   // backpressure x3
        add(0, 0, 0, 4'hF,  0, 4'b0000, 1, 8'h13, 3);
        add(0, 0, 0, 4'hF,  0, 4'b0000, 1, 8'h13, 3);
        add(0, 0, 0, 4'hF,  1, 4'b0001, 1, 8'h13, 3);   // resume after ptr=3
        add(0, 0, 0, 4'hF,  1, 4'b0010, 1, 8'h10, 0);
        add(0, 1, 2, 4'hF,  1, 4'b0100, 1, 8'h11, 1);   // fixed select ch2
        add(0, 1, 2, 4'hF,  1, 4'b0100, 1, 8'h12, 2);
        add(0, 1, 2, 4'hB,  1, 4'b0000, 1, 8'h12, 2);   // ch2 idle: drain
        add(0, 1, 2, 4'hB,  1, 4'b0000, 0, 8'h12, 2);
        add(0, 0, 0, 4'hF,  1, 4'b1000, 0, 8'h12, 2);   // ptr moved by fixed mode
        add(0, 1, 0, 4'hF,  1, 4'b0001, 1, 8'h13, 3);
        add(0, 0, 0, 4'hF,  0, 4'b0000, 1, 8'h10, 0);   // mode change under stall
        add(1, 0, 0, 4'hF,  0, 4'b0000, 1, 8'h10, 0);   // mid-stream reset
        add(0, 0, 0, 4'hF,  1, 4'b0001, 0, 8'h00, 0);
        add(0, 0, 0, 4'hF,  1, 4'b0010, 1, 8'h10, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            mode      = vecs[i].mode;
            fix_sel   = vecs[i].fix_sel;
            in_valid  = vecs[i].valid;
            out_ready = vecs[i].ordy;
            #2;
            check($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_ov,
                  vecs[i].exp_od, vecs[i].exp_ch);
            @(posedge clk); #1;
        end

        // No requests with the consumer ready: register empties, data and channel hold.
        in_valid = 4'h0; out_ready = 1'b1; rst = 1'b0; mode = 1'b0;
        #2;
        check("idle_drain", 4'b0000, 1'b1, 8'h11, 2'd1);
        @(posedge clk); #1;
        check("idle_empty", 4'b0000, 1'b0, 8'h11, 2'd1);

        // Single requester ch2 under alternating stall, simultaneous drain and refill.
        in_valid = 4'b0100; out_ready = 1'b0;
        #2;
        check("ch2_load", 4'b0100, 1'b0, 8'h11, 2'd1);
        @(posedge clk); #1;
        check("ch2_stall", 4'b0000, 1'b1, 8'h12, 2'd2);
        out_ready = 1'b1;
        #1;
        check("ch2_refill", 4'b0100, 1'b1, 8'h12, 2'd2);
        @(posedge clk); #1;
        in_valid = 4'b0000;
        #1;
        check("ch2_again", 4'b0000, 1'b1, 8'h12, 2'd2);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
